// File: rtl/prog_clk_div.sv
// prog_clk_div: runtime-programmable clock divider with a registered,
// glitch-free divided clock, a rising-edge tick, enable/stop control and a
// shadowed divisor that only takes effect at a period boundary.
module prog_clk_div #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_div,
    input  logic             i_load,
    output logic             o_gen_clk,
    output logic             o_tick,
    output logic             o_running
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             gen_q, gen_d;
    logic             tick_q, tick_d;
    logic             run_q, run_d;

    // Ratio that would become active at a boundary taken on this edge. A load
    // strobe on the boundary edge wins over the held shadow value; ratios
    // below 2 are clamped here, when they become active.
    logic [CNT_W-1:0] nxt_src, nxt_div, nxt_h_m1, act_l_m1;

    // Boundary ratio selection and phase-length preloads
    always_comb begin
        nxt_src  = i_load ? i_div : shadow_q;
        nxt_div  = (nxt_src < MIN_DIV) ? MIN_DIV : nxt_src;
        // H-1 = ((N+1)>>1)-1 = (N-1)>>1 for N>=2; this form cannot overflow
        // even at N = 2^CNT_W-1.
        nxt_h_m1 = (nxt_div - ONE) >> 1;
        // L-1 = (N>>1)-1; active ratio is always >= 2 so L >= 1.
        act_l_m1 = (active_q >> 1) - ONE;
    end

    // Next-state and output logic for the IDLE/HIGH/LOW sequencer
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        shadow_d = i_load ? i_div : shadow_q;
        gen_d    = gen_q;
        tick_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                gen_d = 1'b0;
                if (i_en) begin
                    state_d  = HIGH;
                    active_d = nxt_div;
                    cnt_d    = nxt_h_m1;
                    gen_d    = 1'b1;
                    tick_d   = 1'b1;
                end
            end
            HIGH: begin
                if (cnt_q == '0) begin
                    state_d = LOW;
                    cnt_d   = act_l_m1;
                    gen_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - ONE;
                    gen_d = 1'b1;
                end
            end
            LOW: begin
                if (cnt_q == '0) begin
                    if (i_en) begin
                        state_d  = HIGH;
                        active_d = nxt_div;
                        cnt_d    = nxt_h_m1;
                        gen_d    = 1'b1;
                        tick_d   = 1'b1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        gen_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                    gen_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                gen_d   = 1'b0;
            end
        endcase

        run_d = (state_d != IDLE);
    end

    // State registers; every output is taken straight from a flop
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            active_q <= DEF_DIV;
            shadow_q <= DEF_DIV;
            gen_q    <= 1'b0;
            tick_q   <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            shadow_q <= shadow_d;
            gen_q    <= gen_d;
            tick_q   <= tick_d;
            run_q    <= run_d;
        end
    end

    assign o_gen_clk = gen_q;
    assign o_tick    = tick_q;
    assign o_running = run_q;

endmodule

// File: tb/tb_prog_clk_div.sv
// tb_prog_clk_div: directed stimulus with a scoreboard queue; the driver
// pushes the expected {gen_clk, tick, running} for each edge and a monitor
// pops and compares on the following falling edge.
module tb_prog_clk_div;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic [15:0] div = '0;
    logic        load = 1'b0;
    logic        gen_clk, tick, running;

    typedef struct {
        logic [2:0] exp;
        int         id;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    prog_clk_div #(.CNT_W(16), .DEFAULT_DIV(4)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_en     (en),
        .i_div    (div),
        .i_load   (load),
        .o_gen_clk(gen_clk),
        .o_tick   (tick),
        .o_running(running)
    );

    always #5 clk = ~clk;

    // Monitor: compares outputs settled after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({gen_clk, tick, running} !== e.exp) begin
                    errors++;
                    $display("FAIL step%0d gen/tick/run: got %b%b%b expected %b",
                             e.id, gen_clk, tick, running, e.exp);
                end
            end
        end
    end

    // One clock: drive inputs, record the outputs expected after the edge
    task automatic cyc(input bit r, input bit e, input bit ld, input logic [15:0] d,
                       input bit g, input bit t, input bit run);
        exp_t x;
        @(negedge clk);
        #1;
        rst_n = r; en = e; load = ld; div = d;
        x.exp = {g, t, run};
        x.id  = step_id;
        q.push_back(x);
        step_id++;
    endtask

    // One full period of h high / l low cycles. Step 0 is the boundary edge
    // (en=1); later steps drive en_rest. Optional load strobe at step ld_idx.
    task automatic per(input int h, input int l, input bit en_rest,
                       input int ld_idx, input logic [15:0] ld_div);
        for (int i = 0; i < h + l; i++) begin
            bit e;
            bit ld;
            e  = (i == 0) ? 1'b1 : en_rest;
            ld = (i == ld_idx);
            cyc(1'b1, e, ld, ld ? ld_div : 16'd0, (i < h), (i == 0), 1'b1);
        end
    endtask

    task automatic idle(input bit ld, input logic [15:0] d);
        cyc(1'b1, 1'b0, ld, d, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset held with en=1: outputs stay 0
        cyc(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
        // Release: high on the first edge, then 1,1,0,0 at default N=4
        per(2, 2, 1'b1, -1, 16'd0);
        per(2, 2, 1'b1, -1, 16'd0);
        per(2, 2, 1'b1, -1, 16'd0);
        per(2, 2, 1'b0, -1, 16'd0);
        idle(1'b0, 16'd0);
        idle(1'b0, 16'd0);

        // Load 5 while idle -> 3/2
        idle(1'b1, 16'd5);
        per(3, 2, 1'b1, -1, 16'd0);
        per(3, 2, 1'b0, -1, 16'd0);
        idle(1'b0, 16'd0);

        // Load 64 -> 32/32
        idle(1'b1, 16'd64);
        per(32, 32, 1'b0, -1, 16'd0);
        idle(1'b0, 16'd0);

        // Back to 4, load 6 mid-HIGH: current 2/2 completes, then 3/3
        idle(1'b1, 16'd4);
        per(2, 2, 1'b1, 1, 16'd6);
        per(3, 3, 1'b1, -1, 16'd0);
        // Load 8 on the boundary edge itself: used at once
        per(4, 4, 1'b1, 0, 16'd8);
        // en dropped on the first HIGH cycle: period completes, then IDLE
        per(4, 4, 1'b0, -1, 16'd0);
        idle(1'b0, 16'd0);
        // en low through most of the period, reasserted in LOW: no gap
        per(4, 4, 1'b0, -1, 16'd0);
        per(4, 4, 1'b0, -1, 16'd0);
        idle(1'b0, 16'd0);

        // Clamp: 0 and 1 both behave as N=2
        idle(1'b1, 16'd0);
        per(1, 1, 1'b1, -1, 16'd0);
        per(1, 1, 1'b1, -1, 16'd0);
        per(1, 1, 1'b1, 0, 16'd1);
        per(1, 1, 1'b0, -1, 16'd0);
        idle(1'b0, 16'd0);

        // Reset pulsed mid-HIGH at N=10; next run uses default N=4
        idle(1'b1, 16'd10);
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 16'd0);
        per(2, 2, 1'b0, -1, 16'd0);
        idle(1'b0, 16'd0);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #2;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
